// File: rtl/isp_pkg.sv
// Shared ISP pipeline definitions.
// Pixel/word widths, RGB565 field positions, packing helper.
package isp_pkg;

   localparam int PIX_W  = 16;
   localparam int WORD_W = 32;

   localparam int R_MSB = 15;
   localparam int R_LSB = 11;
   localparam int G_MSB = 10;
   localparam int G_LSB = 5;
   localparam int B_MSB = 4;
   localparam int B_LSB = 0;

   typedef struct packed {
      logic [R_MSB-R_LSB:0] r;
      logic [G_MSB-G_LSB:0] g;
      logic [B_MSB-B_LSB:0] b;
   } rgb565_t;

   // Pair two pixels into one word; swap puts the first pixel high.
   function automatic logic [WORD_W-1:0] pack_pair(
      input logic [PIX_W-1:0] first,
      input logic [PIX_W-1:0] second,
      input logic             swap
   );
      pack_pair = swap ? {first, second} : {second, first};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered show-ahead output.
// Head entry is always presented on dout while not empty.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_nxt;
   logic [LW-1:0]    count;
   logic [WIDTH-1:0] dout_q;
   logic             do_pop;
   logic             do_push;

   assign full    = (count == LW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rd_nxt  = rd_ptr + 1'b1;
   assign level   = count;
   assign dout    = dout_q;

   // Storage array; written only on accepted pushes.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers and occupancy; both pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_nxt;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Show-ahead register: reload from next entry or bypass din.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q <= '0;
      end else if (do_pop) begin
         if (count > LW'(1))  dout_q <= mem[rd_nxt];
         else if (do_push)    dout_q <= din;
      end else if (empty && do_push) begin
         dout_q <= din;
      end
   end

endmodule

// File: rtl/rgb565_pack32.sv
// RGB565 pixel pair packer feeding a word FIFO.
// Tracks per-frame word count and sticky overflow.
module rgb565_pack32
   import isp_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 17,
   parameter int PIX_ORDER  = 0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            frame_start,
   input  logic [PIX_W-1:0]                pix_in,
   input  logic                            pix_en,
   output logic [WORD_W-1:0]               wdata,
   output logic                            wvalid,
   input  logic                            wready,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic [CNT_W-1:0]                word_cnt,
   output logic                            overflow
);

   localparam logic SWAP = (PIX_ORDER != 0);

   logic              half;
   logic [PIX_W-1:0]  hold;
   logic              push_req;
   logic              push_ok;
   logic              pop;
   logic              full;
   logic              empty;
   logic [WORD_W-1:0] word;

   assign word     = pack_pair(hold, pix_in, SWAP);
   assign push_req = pix_en & half & ~frame_start;
   assign pop      = wvalid & wready;
   assign push_ok  = push_req & (~full | pop);
   assign wvalid   = ~empty;

   // Pair state; frame_start drops a dangling pixel before capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         half <= 1'b0;
         hold <= '0;
      end else if (frame_start) begin
         half <= pix_en;
         if (pix_en) hold <= pix_in;
      end else if (pix_en) begin
         half <= ~half;
         if (!half) hold <= pix_in;
      end
   end

   // Saturating count of words accepted this frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt <= '0;
      end else if (frame_start) begin
         word_cnt <= '0;
      end else if (push_ok && (word_cnt != '1)) begin
         word_cnt <= word_cnt + 1'b1;
      end
   end

   // Sticky flag for words dropped against a full FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (frame_start) begin
         overflow <= 1'b0;
      end else if (push_req && !push_ok) begin
         overflow <= 1'b1;
      end
   end

   sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_ok),
      .din   (word),
      .pop   (pop),
      .dout  (wdata),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

endmodule

// File: tb/tb_rgb565_pack32.sv
// Testbench for rgb565_pack32: queue-based model plus directed pins.
// Two instances share stimulus: default order, and swapped order with a narrow counter.
module tb_rgb565_pack32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_start = 1'b0;
   logic [15:0] pix_in = '0;
   logic        pix_en = 1'b0;
   logic        wready = 1'b0;

   logic [31:0] wdata0, wdata1;
   logic        wvalid0, wvalid1;
   logic [3:0]  level0, level1;
   logic [16:0] cnt0;
   logic [3:0]  cnt1;
   logic        ovf0, ovf1;

   int checks = 0;
   int failures = 0;
   bit started = 0;

   always #5 clk = ~clk;

   rgb565_pack32 #(.FIFO_DEPTH(8), .CNT_W(17), .PIX_ORDER(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .pix_in(pix_in), .pix_en(pix_en), .wdata(wdata0),
      .wvalid(wvalid0), .wready(wready), .fifo_level(level0),
      .word_cnt(cnt0), .overflow(ovf0));

   rgb565_pack32 #(.FIFO_DEPTH(8), .CNT_W(4), .PIX_ORDER(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .pix_in(pix_in), .pix_en(pix_en), .wdata(wdata1),
      .wvalid(wvalid1), .wready(wready), .fifo_level(level1),
      .word_cnt(cnt1), .overflow(ovf1));

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: queue holds words as {second,first}; count is unbounded.
   logic [31:0] mq[$];
   bit          m_half;
   logic [15:0] m_hold;
   int          m_cnt;
   bit          m_ovf;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_half = 0;
         m_hold = '0;
         m_cnt  = 0;
         m_ovf  = 0;
      end else begin
         bit pop_now;
         pop_now = (mq.size() != 0) && wready;
         if (pop_now) void'(mq.pop_front());
         if (frame_start) begin
            m_half = pix_en;
            m_cnt  = 0;
            m_ovf  = 0;
            if (pix_en) m_hold = pix_in;
         end else if (pix_en) begin
            if (!m_half) begin
               m_hold = pix_in;
               m_half = 1;
            end else begin
               m_half = 0;
               if (mq.size() < 8) begin
                  mq.push_back({pix_in, m_hold});
                  m_cnt++;
               end else begin
                  m_ovf = 1;
               end
            end
         end
      end
   end

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   always @(negedge clk) begin
      if (started) begin
         logic [31:0] h;
         bit ev;
         ev = (mq.size() != 0);
         chk("wvalid0", 32'(wvalid0), 32'(ev));
         chk("wvalid1", 32'(wvalid1), 32'(ev));
         if (ev) begin
            h = mq[0];
            chk("wdata0", wdata0, h);
            chk("wdata1", wdata1, {h[15:0], h[31:16]});
         end
         chk("level0", 32'(level0), 32'(mq.size()));
         chk("level1", 32'(level1), 32'(mq.size()));
         chk("cnt0", 32'(cnt0), 32'(sat(m_cnt, 131071)));
         chk("cnt1", 32'(cnt1), 32'(sat(m_cnt, 15)));
         chk("ovf0", 32'(ovf0), 32'(m_ovf));
         chk("ovf1", 32'(ovf1), 32'(m_ovf));
      end
   end

   task automatic cyc(input logic fs, input logic en,
                      input logic [15:0] px, input logic rdy);
      frame_start = fs;
      pix_en      = en;
      pix_in      = px;
      wready      = rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_wvalid", 32'(wvalid0), 32'd0);
      chk("rst_wdata", wdata0, 32'd0);
      chk("rst_level", 32'(level0), 32'd0);
      chk("rst_cnt", 32'(cnt0), 32'd0);
      chk("rst_ovf", 32'(ovf0), 32'd0);
      started = 1;

      // Basic pairing and one-cycle latency.
      cyc(0, 1, 16'h1111, 1);
      chk("t1_novalid", 32'(wvalid0), 32'd0);
      cyc(0, 1, 16'h2222, 1);
      chk("t1_v1", 32'(wvalid0), 32'd1);
      chk("t1_w1", wdata0, 32'h22221111);
      chk("t1_w1_sw", wdata1, 32'h11112222);
      cyc(0, 1, 16'h3333, 1);
      cyc(0, 1, 16'h4444, 1);
      chk("t1_w2", wdata0, 32'h44443333);
      chk("t1_cnt", 32'(cnt0), 32'd2);

      // Swapped order.
      cyc(1, 0, 16'h0, 1);
      cyc(0, 1, 16'hF800, 1);
      cyc(0, 1, 16'h001F, 1);
      chk("t2_sw", wdata1, 32'hF800001F);
      chk("t2_nosw", wdata0, 32'h001FF800);

      // Fill and overflow.
      cyc(1, 0, 16'h0, 1);
      cyc(0, 0, 16'h0, 1);
      for (int i = 0; i < 18; i++) cyc(0, 1, 16'h0100 + 16'(i), 0);
      chk("t3_level", 32'(level0), 32'd8);
      chk("t3_ovf", 32'(ovf0), 32'd1);
      chk("t3_cnt", 32'(cnt0), 32'd8);
      chk("t3_head", wdata0, 32'h01010100);

      // Push into full FIFO with simultaneous pop.
      cyc(1, 0, 16'h0, 0);
      chk("t4_ovf_clr", 32'(ovf0), 32'd0);
      cyc(0, 1, 16'h5555, 0);
      cyc(0, 1, 16'h6666, 1);
      chk("t4_level", 32'(level0), 32'd8);
      chk("t4_ovf", 32'(ovf0), 32'd0);
      chk("t4_cnt", 32'(cnt0), 32'd1);
      chk("t4_head", wdata0, 32'h01030102);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         if (!wvalid0) break;
         n++;
         cyc(0, 0, 16'h0, 1);
      end
      chk("t4_drained", 32'(n), 32'd8);

      // frame_start coincident with a pixel.
      cyc(0, 1, 16'hAAAA, 1);
      cyc(1, 1, 16'hBBBB, 1);
      chk("t5_novalid", 32'(wvalid0), 32'd0);
      cyc(0, 1, 16'hCCCC, 1);
      chk("t5_word", wdata0, 32'hCCCCBBBB);
      chk("t5_cnt", 32'(cnt0), 32'd1);

      // Reset mid-frame with words buffered and a half pair.
      cyc(0, 0, 16'h0, 1);
      for (int i = 0; i < 7; i++) cyc(0, 1, 16'h0700 + 16'(i), 0);
      chk("t6_level", 32'(level0), 32'd3);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_wvalid", 32'(wvalid0), 32'd0);
      chk("t6_level0", 32'(level0), 32'd0);
      chk("t6_cnt", 32'(cnt0), 32'd0);
      chk("t6_ovf", 32'(ovf0), 32'd0);
      rst_n = 1'b1;
      cyc(0, 0, 16'h0, 1);
      cyc(0, 1, 16'h1234, 1);
      cyc(0, 1, 16'h5678, 1);
      chk("t6_after", wdata0, 32'h56781234);

      // Random traffic, including counter saturation on the narrow instance.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 9) < 7),
             16'($urandom()),
             ($urandom_range(0, 3) != 0));
      end
      for (int i = 0; i < 60; i++) cyc(0, 1, 16'($urandom()), 1);
      chk("rnd_sat", 32'(cnt1), 32'd15);

      started = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
